store_rmw_ctrl: RTL and testbench

- Sequencer for sw/sh/sb in the multicycle MIPS datapath; owns the memory port for the duration of a store.
- Full-word stores write directly.
- Sub-word stores do read-modify-write: read the target word into an internal MDR copy, merge the low lanes from the register-B value, write the result back.
- Sits between register B / address ALU output and the unified memory; the control unit pulses start and waits for done.

---
 rtl/store_rmw_ctrl_pkg.sv | 30 +++
 rtl/store_merge.sv | 47 ++++
 rtl/store_rmw_ctrl.sv | 150 +++++++++++++++
 tb/tb_store_rmw_ctrl.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_rmw_ctrl_pkg.sv
// Shared definitions for the store read-modify-write sequencer: store size
// codes, FSM state encoding and the alignment check used at request time.
package store_rmw_ctrl_pkg;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;
  localparam logic [1:0] SZ_ILL  = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StWrite,
    StDone,
    StErr
  } state_e;

  // An illegal size is reported the same way as a misaligned address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SZ_WORD: bad = (addr_lo != 2'b00);
      SZ_HALF: bad = addr_lo[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational merge of store data into the word read back from memory.
// With STORE_RMW_BYTE_LANE_EN defined the target lane follows the address
// (big-endian lane numbering); otherwise the low lane is always replaced.
module store_merge
  import store_rmw_ctrl_pkg::*;
(
  input  logic [31:0] mdr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  output logic [31:0] merged_o
);

`ifndef STORE_RMW_BYTE_LANE_EN
  logic unused_addr_lo;
  assign unused_addr_lo = ^addr_lo_i;
`endif

  // Select which lanes of the old word are replaced by the low lane of wdata.
  always_comb begin
    merged_o = wdata_i;
    case (size_i)
      SZ_HALF: begin
`ifdef STORE_RMW_BYTE_LANE_EN
        merged_o = addr_lo_i[1] ? {mdr_i[31:16], wdata_i[15:0]}
                                : {wdata_i[15:0], mdr_i[15:0]};
`else
        merged_o = {mdr_i[31:16], wdata_i[15:0]};
`endif
      end
      SZ_BYTE: begin
`ifdef STORE_RMW_BYTE_LANE_EN
        case (addr_lo_i)
          2'd0:    merged_o = {wdata_i[7:0], mdr_i[23:0]};
          2'd1:    merged_o = {mdr_i[31:24], wdata_i[7:0], mdr_i[15:0]};
          2'd2:    merged_o = {mdr_i[31:16], wdata_i[7:0], mdr_i[7:0]};
          default: merged_o = {mdr_i[31:8], wdata_i[7:0]};
        endcase
`else
        merged_o = {mdr_i[31:8], wdata_i[7:0]};
`endif
      end
      default: merged_o = wdata_i;
    endcase
  end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer for sw/sh/sb: word stores write directly, sub-word stores
// read the target word, merge and write back. All outputs are flops loaded
// from the next-state decode so nothing is combinational from start.
// Optional build macro: STORE_RMW_BYTE_LANE_EN (address-selected merge lane,
// word-aligned memory address).
module store_rmw_ctrl
  import store_rmw_ctrl_pkg::*;
#(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        misalign
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(MEM_LAT - 1);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] mdr_q, mdr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] mem_wdata_q, mem_wdata_d;
  logic        mem_wr_q, mem_wr_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        misalign_q, misalign_d;
  logic [31:0] merged;

  // Merge works on next-state values so the write data is ready as WRITE begins.
  store_merge u_merge (
    .mdr_i     (mdr_d),
    .wdata_i   (wdata_d),
    .size_i    (size_d),
    .addr_lo_i (addr_d[1:0]),
    .merged_o  (merged)
  );

  // Next-state sequencing and request latch.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    wdata_d = wdata_q;
    mdr_d   = mdr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          addr_d  = addr;
          size_d  = size;
          wdata_d = wdata;
          cnt_d   = '0;
          if (is_misaligned(size, addr[1:0])) begin
            state_d = StErr;
          end else if (size == SZ_WORD) begin
            state_d = StWrite;
          end else begin
            state_d = StRead;
          end
        end
      end
      StRead: begin
        if (cnt_q == LastCnt) begin
          mdr_d   = mem_rdata;
          cnt_d   = '0;
          state_d = StWrite;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StWrite: state_d = StDone;
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output decode from the next state, registered below.
  always_comb begin
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    mem_wr_d    = (state_d == StWrite);
    busy_d      = (state_d != StIdle);
    done_d      = (state_d == StDone);
    misalign_d  = (state_d == StErr);
    if (state_d == StRead || state_d == StWrite) begin
`ifdef STORE_RMW_BYTE_LANE_EN
      mem_addr_d = {addr_d[31:2], 2'b00};
`else
      mem_addr_d = addr_d;
`endif
    end
    if (state_d == StWrite) begin
      mem_wdata_d = merged;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      mdr_q       <= '0;
      cnt_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wr_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      misalign_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      mdr_q       <= mdr_d;
      cnt_q       <= cnt_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wr_q    <= mem_wr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      misalign_q  <= misalign_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wr    = mem_wr_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign misalign  = misalign_q;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Self-checking bench for store_rmw_ctrl with a latency-modelled memory.
module tb_store_rmw_ctrl;

  localparam int MEM_LAT = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  size = 2'd0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] mem_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_wr;
  logic        busy;
  logic        done;
  logic        misalign;

  int tests = 0;
  int fails = 0;

  store_rmw_ctrl #(.MEM_LAT(MEM_LAT)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wr    (mem_wr),
    .busy      (busy),
    .done      (done),
    .misalign  (misalign)
  );

  always #5 clk = ~clk;

  // Memory: 256 words, preload port for the bench, returns garbage until the
  // read address has been held for MEM_LAT cycles.
  logic [31:0] mem [256];
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  int          rd_run = 0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
    if (busy && !mem_wr && !done && !misalign) rd_run <= rd_run + 1;
    else rd_run <= 0;
  end

  assign mem_rdata = (rd_run >= MEM_LAT - 1) ? mem[mem_addr[9:2]] : 32'hBAD0_BAD0;

  // Reference model.
  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && (a % 2) != 0) || (sz == 2'd0 && (a % 4) != 0);
  endfunction

  function automatic logic [31:0] model_data(input logic [1:0] sz, input logic [31:0] a,
                                             input logic [31:0] wd, input logic [31:0] old);
    int          sh;
    logic [31:0] m;
    if (sz == 2'd0) return wd;
    sh = 0;
`ifdef STORE_RMW_BYTE_LANE_EN
    if (sz == 2'd1) sh = (a[1] == 1'b1) ? 0 : 16;
    else sh = 8 * (3 - int'(a % 4));
`endif
    m = ((sz == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF) << sh;
    return (old & ~m) | ((wd << sh) & m);
  endfunction

  function automatic logic [31:0] model_addr(input logic [31:0] a);
`ifdef STORE_RMW_BYTE_LANE_EN
    return a & ~32'd3;
`else
    return a;
`endif
  endfunction

  // Observations of the last run_op.
  int          n_wr, n_done, n_mis, n_rd;
  int          wr_cyc, done_cyc, mis_cyc;
  logic [31:0] wr_data, wr_addr, rd_addr;
  logic [15:0] busy_hist;

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    pre_idx = a[9:2];
    pre_val = v;
    pre_en  = 1'b1;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  // Issue one request in cycle 0, keep start high until cycle `hold`, observe 14 cycles.
  task automatic run_op(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                        input int hold);
    n_wr = 0; n_done = 0; n_mis = 0; n_rd = 0;
    wr_cyc = -1; done_cyc = -1; mis_cyc = -1;
    wr_data = '0; wr_addr = '0; rd_addr = '0; busy_hist = '0;
    @(negedge clk);
    start = 1'b1; size = sz; addr = a; wdata = wd;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c >= hold) start = 1'b0;
      busy_hist[c] = busy;
      if (mem_wr) begin
        if (n_wr == 0) begin wr_cyc = c; wr_data = mem_wdata; wr_addr = mem_addr; end
        n_wr++;
      end
      if (done) begin if (n_done == 0) done_cyc = c; n_done++; end
      if (misalign) begin if (n_mis == 0) mis_cyc = c; n_mis++; end
      if (busy && !mem_wr && !done && !misalign) begin rd_addr = mem_addr; n_rd++; end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, misalign, mem_wr} !== 4'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b mis=%b wr=%b addr=%h wdata=%h, expected all 0",
               busy, done, misalign, mem_wr, mem_addr, mem_wdata);
      fails++;
    end
    start = 1'b1; size = 2'd0; addr = 32'h100;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mem_wr !== 1'b0) begin
      $display("FAIL reset_beats_start: got busy=%b wr=%b, expected 0 0", busy, mem_wr);
      fails++;
    end
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin
      $display("FAIL reset_idle_after: got busy=%b, expected 0", busy);
      fails++;
    end
  endtask

  task automatic test_word();
    run_op(2'd0, 32'h100, 32'hDEADBEEF, 1);
    tests++;
    if (wr_cyc !== 1 || wr_data !== 32'hDEADBEEF || wr_addr !== 32'h100 || n_wr !== 1) begin
      $display("FAIL word_write: got cyc=%0d data=%h addr=%h n=%0d, expected 1 deadbeef 100 1",
               wr_cyc, wr_data, wr_addr, n_wr);
      fails++;
    end
    tests++;
    if (done_cyc !== 2 || n_done !== 1 || n_rd !== 0) begin
      $display("FAIL word_done: got done_cyc=%0d n_done=%0d reads=%0d, expected 2 1 0",
               done_cyc, n_done, n_rd);
      fails++;
    end
  endtask

  task automatic test_half();
    logic [31:0] exp;
`ifdef STORE_RMW_BYTE_LANE_EN
    exp = 32'hBBBB3344;
`else
    exp = 32'h1122BBBB;
`endif
    preload(32'h200, 32'h11223344);
    run_op(2'd1, 32'h200, 32'hAAAABBBB, 1);
    tests++;
    if (wr_cyc !== MEM_LAT + 1 || wr_data !== exp || n_rd !== MEM_LAT) begin
      $display("FAIL half_write: got cyc=%0d data=%h reads=%0d, expected %0d %h %0d",
               wr_cyc, wr_data, n_rd, MEM_LAT + 1, exp, MEM_LAT);
      fails++;
    end
    tests++;
    if (done_cyc !== MEM_LAT + 2 || n_done !== 1) begin
      $display("FAIL half_done: got cyc=%0d n=%0d, expected %0d 1", done_cyc, n_done, MEM_LAT + 2);
      fails++;
    end
  endtask

  task automatic test_byte();
    logic [31:0] exp;
`ifdef STORE_RMW_BYTE_LANE_EN
    exp = 32'hCC223344;
`else
    exp = 32'h112233CC;
`endif
    preload(32'h300, 32'h11223344);
    run_op(2'd2, 32'h300, 32'h000000CC, 1);
    tests++;
    if (wr_cyc !== MEM_LAT + 1 || wr_data !== exp || done_cyc !== MEM_LAT + 2) begin
      $display("FAIL byte_write: got cyc=%0d data=%h done=%0d, expected %0d %h %0d",
               wr_cyc, wr_data, done_cyc, MEM_LAT + 1, exp, MEM_LAT + 2);
      fails++;
    end
    tests++;
    if (mem[8'hC0] !== exp) begin
      $display("FAIL byte_mem_update: got %h, expected %h", mem[8'hC0], exp);
      fails++;
    end
  endtask

  task automatic test_misalign();
    run_op(2'd0, 32'h102, 32'h12345678, 1);
    tests++;
    if (mis_cyc !== 1 || n_mis !== 1 || n_wr !== 0 || n_done !== 0 || busy_hist[2] !== 1'b0) begin
      $display("FAIL misalign_word: got mis=%0d n_mis=%0d n_wr=%0d n_done=%0d busy2=%b, expected 1 1 0 0 0",
               mis_cyc, n_mis, n_wr, n_done, busy_hist[2]);
      fails++;
    end
    run_op(2'd3, 32'h100, 32'h12345678, 1);
    tests++;
    if (mis_cyc !== 1 || n_wr !== 0 || n_done !== 0 || busy_hist[2] !== 1'b0) begin
      $display("FAIL misalign_size3: got mis=%0d n_wr=%0d n_done=%0d busy2=%b, expected 1 0 0 0",
               mis_cyc, n_wr, n_done, busy_hist[2]);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    int wrs = 0;
    int dns = 0;
    preload(32'h204, 32'h55667788);
    @(negedge clk);
    start = 1'b1; size = 2'd1; addr = 32'h204; wdata = 32'h0000ABCD;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || mem_wr !== 1'b0 || mem_addr !== 32'd0 || mem_wdata !== 32'd0) begin
      $display("FAIL reset_mid_state: got busy=%b wr=%b addr=%h wdata=%h, expected 0 0 0 0",
               busy, mem_wr, mem_addr, mem_wdata);
      fails++;
    end
    reset = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mem_wr) wrs++;
      if (done) dns++;
    end
    tests++;
    if (wrs !== 0 || dns !== 0 || mem[8'h81] !== 32'h55667788) begin
      $display("FAIL reset_mid_nowrite: got writes=%0d dones=%0d mem=%h, expected 0 0 55667788",
               wrs, dns, mem[8'h81]);
      fails++;
    end
  endtask

  task automatic test_busy_ignore();
    run_op(2'd1, 32'h208, 32'h00001234, MEM_LAT + 3);
    tests++;
    if (n_done !== 1 || n_wr !== 1 || done_cyc !== MEM_LAT + 2) begin
      $display("FAIL busy_ignore: got n_done=%0d n_wr=%0d done_cyc=%0d, expected 1 1 %0d",
               n_done, n_wr, done_cyc, MEM_LAT + 2);
      fails++;
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] wrv = '0;
    logic [15:0] dnv = '0;
    logic [31:0] second = '0;
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      start = (c == 0 || c == 3);
      size  = 2'd0;
      addr  = (c < 3) ? 32'h110 : 32'h114;
      wdata = (c < 3) ? 32'hCAFE0001 : 32'hCAFE0002;
      @(negedge clk);
      wrv[c+1] = mem_wr;
      dnv[c+1] = done;
      if (mem_wr && c + 1 == 4) second = mem_wdata;
    end
    start = 1'b0;
    tests++;
    if (wrv !== 16'h0012 || dnv !== 16'h0024) begin
      $display("FAIL back_to_back_timing: got wr=%h done=%h, expected 0012 0024", wrv, dnv);
      fails++;
    end
    tests++;
    if (second !== 32'hCAFE0002) begin
      $display("FAIL back_to_back_data: got %h, expected cafe0002", second);
      fails++;
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      logic [1:0]  sz;
      logic [31:0] a, wd, old, exp;
      sz  = 2'($urandom_range(0, 3));
      a   = 32'($urandom_range(0, 1023));
      wd  = $urandom;
      old = $urandom;
      preload(a, old);
      run_op(sz, a, wd, 1);
      tests++;
      if (model_err(sz, a)) begin
        if (mis_cyc !== 1 || n_wr !== 0 || n_done !== 0) begin
          $display("FAIL rand_err[%0d] sz=%0d a=%h: got mis=%0d n_wr=%0d n_done=%0d, expected 1 0 0",
                   i, sz, a, mis_cyc, n_wr, n_done);
          fails++;
        end
      end else begin
        exp = model_data(sz, a, wd, old);
        if (wr_data !== exp || wr_addr !== model_addr(a) || n_wr !== 1 || n_mis !== 0 ||
            wr_cyc !== ((sz == 2'd0) ? 1 : MEM_LAT + 1) || done_cyc !== wr_cyc + 1) begin
          $display("FAIL rand_store[%0d] sz=%0d a=%h: got data=%h addr=%h cyc=%0d done=%0d, expected %h %h",
                   i, sz, a, wr_data, wr_addr, wr_cyc, done_cyc, exp, model_addr(a));
          fails++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_word();
    test_half();
    test_byte();
    test_misalign();
    test_reset_mid();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
